// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM states and the operand absolute-value helper.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  // Two's-complement magnitude of a w-bit value held zero-extended in v.
  // The caller truncates to w bits, so the most negative value maps to itself.
  function automatic logic [63:0] mdu_abs(input logic [63:0] v, input int w);
    mdu_abs = v[w-1] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator: shift-add for multiply,
// shift / trial-subtract / restore for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
               (i_acc[0] ? {1'b0, i_m} : {(WIDTH+1){1'b0}});
    // Remainder needs one extra bit after the shift before the trial subtract.
    w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_diff   = {1'b0, w_rem_sh} - {2'b00, i_m};
    w_borrow = w_diff[WIDTH+1];
    if (i_div)
      o_acc = {(w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]),
               i_acc[WIDTH-2:0], ~w_borrow};
    else
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/hilo_mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO write port and
// stalls decode while an operation is in flight.
module hilo_mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             we_hilo,
  output logic [WIDTH-1:0] hi_d,
  output logic [WIDTH-1:0] lo_d,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         r_state, w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_m, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q, r_neg_r, r_dz;
  logic               w_is_div, w_is_sgn;
  logic [WIDTH-1:0]   w_op_a, w_op_b, w_q, w_r, w_hi_fix, w_lo_fix;

  assign w_is_div = r_op[1];
  assign w_is_sgn = r_op[0];
  assign w_op_a   = w_is_sgn ? WIDTH'(mdu_abs(64'(r_a), WIDTH)) : r_a;
  assign w_op_b   = w_is_sgn ? WIDTH'(mdu_abs(64'(r_b), WIDTH)) : r_b;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_is_div),
    .i_acc (r_acc),
    .i_m   (r_m),
    .o_acc (w_acc_step)
  );

  // Divide by zero ends with the magnitude of a in the remainder, so the
  // ordinary remainder sign fix restores the original a; only LO is forced.
  always_comb begin
    w_q    = r_acc[WIDTH-1:0];
    w_r    = r_acc[2*WIDTH-1:WIDTH];
    w_prod = r_neg_q ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    if (!w_is_div) begin
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod[WIDTH-1:0];
    end else begin
      w_lo_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~w_q + WIDTH'(1)) : w_q);
      w_hi_fix = r_neg_r ? (~w_r + WIDTH'(1)) : w_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // start is taken only in IDLE; a start seen while busy is held by decode
  // (stall) and re-presented, never queued here.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start && !flush) w_next = ST_PREP;
      ST_PREP: w_next = ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush && r_state != ST_IDLE) w_next = ST_IDLE;
  end

  always_comb begin
    busy    = (r_state != ST_IDLE);
    we_hilo = (r_state == ST_DONE) && !flush;
  end

  assign stall     = busy & (start | rd_hilo);
  assign hi_d      = r_hi;
  assign lo_d      = r_lo;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start && !flush) begin
          r_op <= op;
          r_a  <= a;
          r_b  <= b;
        end
        ST_PREP: begin
          r_neg_q <= w_is_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= w_is_sgn & r_a[WIDTH-1];
          r_dz    <= w_is_div & (r_b == '0);
          // Low half carries the operand shifted out: multiplier or dividend.
          r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_op_a : w_op_b)};
          r_m     <= w_is_div ? w_op_b : w_op_a;
          r_cnt   <= CW'(WIDTH - 1);
        end
        ST_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: if (!flush) begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
